// File: rtl/div_pkg.sv
// Shared types and constants for the shared-divider scheduler and its iterative core.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_DEFAULT_WIDTH = 6;

    // Divide-by-zero quotient is every bit set to this value.
    localparam logic DIV_DBZ_QUOTIENT = 1'b1;

endpackage

// File: rtl/div_core.sv
// Iterative restoring magnitude divider: one shift/subtract step per cycle, WIDTH steps per start.
module div_core
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             active_q;
    logic [WIDTH:0]   rem_shift;
    logic             fits;

    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        fits      = (rem_shift >= {1'b0, dvs_q});
        rem_d     = fits ? WIDTH'(rem_shift - {1'b0, dvs_q}) : rem_shift[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            quo_q    <= dividend_i;
            rem_q    <= '0;
            dvs_q    <= divisor_i;
            cnt_q    <= CW'(WIDTH);
            active_q <= 1'b1;
        end else if (active_q) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                active_q <= 1'b0;
            end
        end
    end

    // done_o flags the cycle of the final step; the outputs are that step's result,
    // so the consumer captures them on the same edge the core finishes.
    assign done_o      = active_q && (cnt_q == CW'(1));
    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one iterative divider among NREQ requesters, with sign
// handling around the magnitude core and a held, tagged response.
module div_sched
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_sign,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divider,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_quotient,
    output logic [WIDTH-1:0]      resp_remainder,
    output logic                  resp_dbz,
    output logic                  busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // requesters hold valid/operands until ready, and the response holds until resp_ready.

    div_state_t       state_q;
    div_state_t       state_d;
    logic [IDW-1:0]   last_id_q;
    logic             grant_found;
    logic [IDW-1:0]   grant_id;
    logic             accept;

    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divider;
    logic             sel_sign;

    logic [IDW-1:0]   op_id_q;
    logic [WIDTH-1:0] op_dividend_q;
    logic             op_qneg_q;
    logic             op_rneg_q;
    logic             op_dbz_q;

    logic [IDW-1:0]   resp_id_q;
    logic [WIDTH-1:0] resp_quo_q;
    logic [WIDTH-1:0] resp_rem_q;
    logic             resp_dbz_q;

    logic             core_done;
    logic [WIDTH-1:0] core_quo;
    logic [WIDTH-1:0] core_rem;

    // One extra bit keeps the most negative value exact before taking its magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH:0] ext;
        ext = sgn ? {v[WIDTH-1], v} : {1'b0, v};
        return WIDTH'(ext[WIDTH] ? (~ext + 1'b1) : ext);
    endfunction

    always_comb begin : rr_pick
        int cand;
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_id_q) + k) % NREQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(cand);
            end
        end
    end

    assign sel_dividend = req_dividend[int'(grant_id) * WIDTH +: WIDTH];
    assign sel_divider  = req_divider[int'(grant_id) * WIDTH +: WIDTH];
    assign sel_sign     = req_sign[grant_id];
    assign accept       = (state_q == IDLE) && grant_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_found) state_d = BUSY;
            BUSY:    if (core_done)   state_d = DONE;
            DONE:    if (resp_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        if (rst_n && accept) begin
            req_ready[grant_id] = 1'b1;
        end
        resp_valid = (state_q == DONE);
        busy       = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id_q     <= IDW'(NREQ - 1);
            op_id_q       <= '0;
            op_dividend_q <= '0;
            op_qneg_q     <= 1'b0;
            op_rneg_q     <= 1'b0;
            op_dbz_q      <= 1'b0;
            resp_id_q     <= '0;
            resp_quo_q    <= '0;
            resp_rem_q    <= '0;
            resp_dbz_q    <= 1'b0;
        end else begin
            if (accept) begin
                last_id_q     <= grant_id;
                op_id_q       <= grant_id;
                op_dividend_q <= sel_dividend;
                op_qneg_q     <= sel_sign & (sel_dividend[WIDTH-1] ^ sel_divider[WIDTH-1]);
                op_rneg_q     <= sel_sign & sel_dividend[WIDTH-1];
                op_dbz_q      <= (sel_divider == '0);
            end
            if (state_q == BUSY && core_done) begin
                resp_id_q  <= op_id_q;
                resp_dbz_q <= op_dbz_q;
                if (op_dbz_q) begin
                    resp_quo_q <= {WIDTH{DIV_DBZ_QUOTIENT}};
                    resp_rem_q <= op_dividend_q;
                end else begin
                    resp_quo_q <= op_qneg_q ? -core_quo : core_quo;
                    resp_rem_q <= op_rneg_q ? -core_rem : core_rem;
                end
            end
        end
    end

    div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (accept),
        .dividend_i  (magnitude(sel_dividend, sel_sign)),
        .divisor_i   (magnitude(sel_divider, sel_sign)),
        .done_o      (core_done),
        .quotient_o  (core_quo),
        .remainder_o (core_rem)
    );

    assign resp_id        = resp_id_q;
    assign resp_quotient  = resp_quo_q;
    assign resp_remainder = resp_rem_q;
    assign resp_dbz       = resp_dbz_q;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched at WIDTH=6, NREQ=4 with hand-computed expected results.
module tb_div_sched;

    localparam int WIDTH = 6;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_sign = '0;
    logic [NREQ*WIDTH-1:0] req_dividend = '0;
    logic [NREQ*WIDTH-1:0] req_divider = '0;
    logic                  resp_valid;
    logic                  resp_ready = 1'b1;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_quotient;
    logic [WIDTH-1:0]      resp_remainder;
    logic                  resp_dbz;
    logic                  busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    div_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_sign       (req_sign),
        .req_dividend   (req_dividend),
        .req_divider    (req_divider),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_dbz       (resp_dbz),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic sgn, input logic [WIDTH-1:0] dvd,
                           input logic [WIDTH-1:0] dvs);
        req_valid[id]                      = 1'b1;
        req_sign[id]                       = sgn;
        req_dividend[id*WIDTH +: WIDTH]    = dvd;
        req_divider[id*WIDTH +: WIDTH]     = dvs;
    endtask

    task automatic wait_grant(input int id, input string tag, output int gcyc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (req_ready !== '0) seen = 1'b1;
        end
        check({tag, " grant"}, req_ready, 32'(1 << id));
        gcyc = cyc;
    endtask

    task automatic wait_resp(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        check({tag, " resp_valid"}, resp_valid, 1);
    endtask

    task automatic run_op(input int id, input logic sgn, input logic [WIDTH-1:0] dvd,
                          input logic [WIDTH-1:0] dvs, input logic [WIDTH-1:0] eq,
                          input logic [WIDTH-1:0] er, input logic edbz, input string tag);
        int g;
        @(posedge clk); #1;
        set_req(id, sgn, dvd, dvs);
        wait_grant(id, tag, g);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        repeat (6) @(negedge clk);
        check({tag, " busy C6"}, busy, 1);
        check({tag, " valid C6"}, resp_valid, 0);
        @(negedge clk);
        check({tag, " valid C7"}, resp_valid, 1);
        check({tag, " id"}, resp_id, id);
        check({tag, " quot"}, resp_quotient, eq);
        check({tag, " rem"}, resp_remainder, er);
        check({tag, " dbz"}, resp_dbz, edbz);
        @(negedge clk);
        check({tag, " busy C8"}, busy, 0);
        check({tag, " valid C8"}, resp_valid, 0);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = '0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    int exp_ids[8] = '{0, 2, 0, 2, 0, 2, 3, 0};
    int g;
    int prev_g;

    initial begin
        // reset state
        #1;
        check("reset outputs",
              {req_ready, resp_valid, resp_id, resp_quotient, resp_remainder, resp_dbz, busy}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // arithmetic cases, one requester at a time
        run_op(1, 1'b0, 6'd13, 6'd4, 6'd3, 6'd1, 1'b0, "unsigned 13/4");
        run_op(2, 1'b1, 6'b110011, 6'b000100, 6'b111101, 6'b111111, 1'b0, "signed -13/4");
        run_op(3, 1'b1, 6'b000111, 6'b111110, 6'b111101, 6'b000001, 1'b0, "signed 7/-2");
        run_op(0, 1'b0, 6'd21, 6'd0, 6'b111111, 6'b010101, 1'b1, "dbz 21/0");
        run_op(1, 1'b1, 6'b100000, 6'b111111, 6'b100000, 6'b000000, 1'b0, "overflow");

        // response stall with a second requester waiting
        resp_ready = 1'b0;
        @(posedge clk); #1;
        set_req(0, 1'b0, 6'd50, 6'd7);
        wait_grant(0, "stall", g);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(2, 1'b0, 6'd45, 6'd5);
        wait_resp("stall");
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("stall hold",
                  {resp_valid, resp_id, resp_quotient, resp_remainder, resp_dbz, req_ready, busy},
                  {1'b1, 2'd0, 6'd7, 6'd1, 1'b0, 4'b0000, 1'b1});
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("stall valid at handshake", resp_valid, 1);
        @(negedge clk);
        check("stall regrant", req_ready, 4'b0100);
        check("stall valid dropped", resp_valid, 0);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        wait_resp("stall second");
        check("stall second result", {resp_id, resp_quotient, resp_remainder}, {2'd2, 6'd9, 6'd0});
        @(negedge clk);

        // contention: requesters 0 and 2 held, then 3 joins
        reset_dut();
        set_req(0, 1'b0, 6'd20, 6'd3);
        set_req(2, 1'b0, 6'd30, 6'd4);
        prev_g = 0;
        for (int n = 0; n < 8; n++) begin
            wait_grant(exp_ids[n], "rr", g);
            if (n > 0) check("rr spacing", g - prev_g, 8);
            prev_g = g;
            @(posedge clk); #1;
            if (n == 4) set_req(3, 1'b0, 6'd9, 6'd2);
            wait_resp("rr");
            check("rr id", resp_id, exp_ids[n]);
        end
        req_valid = '0;
        @(negedge clk);

        // reset in C3 of an operation, then re-issue
        @(posedge clk); #1;
        set_req(1, 1'b0, 6'd13, 6'd4);
        wait_grant(1, "midreset", g);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midreset busy C3", busy, 1);
        rst_n = 1'b0;
        req_valid[1] = 1'b1;
        #1;
        check("midreset outputs",
              {req_ready, resp_valid, resp_id, resp_quotient, resp_remainder, resp_dbz, busy}, 0);
        @(negedge clk);
        check("midreset ready held", req_ready, 0);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rst_n = 1'b1;
        run_op(1, 1'b0, 6'd13, 6'd4, 6'd3, 6'd1, 1'b0, "reissue 13/4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
